// File: rtl/logmul_pkg.sv
// Shared definitions for the serial logarithmic (Mitchell) FP multiplier:
// FSM states, flag bit positions and width/bias/NaN helper functions.
package logmul_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam int FLAG_NAN = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    function automatic int word_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int beat_count(input int exp_w, input int man_w, input int bus_w);
        return (1 + exp_w + man_w) / bus_w;
    endfunction

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Quiet NaN with positive sign, all-ones exponent and only the top
    // mantissa bit set; callers take the low word_width() bits.
    function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/logmul_core.sv
// Combinational Mitchell-approximation multiplier datapath with special-case
// handling. The optional correction term is enabled by LOGMUL_CORR_EN.
module logmul_core
    import logmul_pkg::*;
#(
    parameter int  EXP_W = 5,
    parameter int  MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic [2:0]   flags
);

    localparam int                      BIAS     = exp_bias(EXP_W);
    localparam logic [63:0]             NAN_WORD = canonical_nan(EXP_W, MAN_W);
    localparam logic signed [EXP_W+1:0] BIAS_S   = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] E_ONE    = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_ZERO   = (EXP_W+2)'(0);
    localparam logic signed [EXP_W+1:0] E_MAX    = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]        EXP_ONES = '1;

    logic                      sa, sb, s;
    logic [EXP_W-1:0]          ea, eb;
    logic [MAN_W-1:0]          fa, fb, mant;
    logic [MAN_W:0]            s_sum;
    logic signed [EXP_W+1:0]   e_sum, e_fin;
    logic                      a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
`ifdef LOGMUL_CORR_EN
    logic [3:0]                corr_prod;
    logic [MAN_W:0]            corr_sum;
`endif

    // Log-domain add of exponents and mantissas, then special-case override.
    // Exponent-zero operands count as zero (subnormals are flushed), so a
    // subnormal times Inf is treated the same as 0 times Inf.
    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1];
        s      = sa ^ sb;
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
`ifdef LOGMUL_CORR_EN
        corr_prod = '0;
        corr_sum  = '0;
`endif
        s_sum = {1'b0, fa} + {1'b0, fb};
        e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
        if (s_sum[MAN_W]) begin
            e_fin = e_sum + E_ONE;
            mant  = s_sum[MAN_W-1:0];
        end else begin
            e_fin = e_sum;
`ifdef LOGMUL_CORR_EN
            corr_prod = fa[MAN_W-1:MAN_W-2] * fb[MAN_W-1:MAN_W-2];
            corr_sum  = s_sum + ((MAN_W+1)'(corr_prod) << (MAN_W - 4));
            mant      = corr_sum[MAN_W] ? '1 : corr_sum[MAN_W-1:0];
`else
            mant = s_sum[MAN_W-1:0];
`endif
        end

        r     = {s, e_fin[EXP_W-1:0], mant};
        flags = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            r               = NAN_WORD[W-1:0];
            flags[FLAG_NAN] = 1'b1;
        end else if (a_inf || b_inf) begin
            r = {s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            r = {s, {(W-1){1'b0}}};
        end else if (e_fin >= E_MAX) begin
            r               = {s, EXP_ONES, {MAN_W{1'b0}}};
            flags[FLAG_OVF] = 1'b1;
        end else if (e_fin <= E_ZERO) begin
            r               = {s, {(W-1){1'b0}}};
            flags[FLAG_UNF] = 1'b1;
        end
    end

endmodule

// File: rtl/logmul_serial_afpm.sv
// Beat-serial handshaked front end around logmul_core: collects operand
// beats (LSB beat first), computes in one cycle, streams the result out.
// Optional correction term: define LOGMUL_CORR_EN.
module logmul_serial_afpm
    import logmul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] a_in,
    input  logic [BUS_W-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] y_out,
    output logic             out_last,
    output logic [2:0]       flags
);

    localparam int               W         = word_width(EXP_W, MAN_W);
    localparam int               BEATS     = beat_count(EXP_W, MAN_W, BUS_W);
    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, r_q, r_d;
    logic [2:0]       flags_q, flags_d;
    logic [W-1:0]     core_r;
    logic [2:0]       core_flags;

    logmul_core #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_core (
        .a    (a_q),
        .b    (b_q),
        .r    (core_r),
        .flags(core_flags)
    );

    // Outputs are forced low while reset is held.
    assign in_ready  = !rst && (state_q == ST_LOAD);
    assign out_valid = !rst && (state_q == ST_SEND);
    assign out_last  = out_valid && (cnt_q == LAST_BEAT);
    assign y_out     = r_q[cnt_q*BUS_W +: BUS_W];
    assign flags     = out_valid ? flags_q : 3'b000;

    // State, beat counter, operand, result and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

    // Next-state: gather beats in LOAD, latch result in CALC, drain in SEND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        flags_d = flags_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    a_d[cnt_q*BUS_W +: BUS_W] = a_in;
                    b_d[cnt_q*BUS_W +: BUS_W] = b_in;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_CALC: begin
                r_d     = core_r;
                flags_d = core_flags;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_logmul_serial_afpm.sv
// Scoreboard bench for logmul_serial_afpm at FP16 / 8-bit beats.
// Expected results are pushed when an operand is sent and popped as the
// result beats come out.
module tb_logmul_serial_afpm;

    localparam int BUS_W   = 8;
    localparam int BEATS   = 2;
    localparam int TIMEOUT = 20;

    typedef struct packed {
        logic [15:0] r;
        logic [2:0]  f;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [2:0]  f;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] a_in;
    logic [BUS_W-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] y_out;
    logic             out_last;
    logic [2:0]       flags;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    logmul_serial_afpm dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out),
        .out_last (out_last),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    // Drives one operand pair beat by beat and records its expected result.
    // Returns at the negedge after the last accepting edge.
    task automatic send_operand(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] r, input logic [2:0] f);
        int cyc;
        sb.push_back(exp_t'{r: r, f: f});
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            cyc = 0;
            while (in_ready !== 1'b1 && cyc < TIMEOUT) begin
                @(negedge clk);
                cyc++;
            end
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL in_ready_timeout beat %0d: in_ready=%b required 1", k, in_ready);
            end
            in_valid = 1'b1;
            a_in     = a[k*BUS_W +: BUS_W];
            b_in     = b[k*BUS_W +: BUS_W];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, y_out, out_last, flags} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b y=%h last=%b flags=%b required all 0",
                     in_ready, out_valid, y_out, out_last, flags);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    // -2.0 result held under backpressure with junk on the input side.
    task automatic test_backpressure();
        exp_t exp;
        int   cyc;
        send_operand(16'h4000, 16'hC000, 16'hC400, 3'b000);
        exp = sb.pop_front();
        for (int k = 0; k < BEATS; k++) begin
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < TIMEOUT) begin
                @(negedge clk);
                cyc++;
            end
            in_valid = 1'b1;
            a_in     = 8'hFF;
            b_in     = 8'hFF;
            for (int s = 0; s < 4; s++) begin
                vectors++;
                if (out_valid !== 1'b1 || y_out !== exp.r[k*BUS_W +: BUS_W] ||
                    out_last !== (k == BEATS-1) || flags !== exp.f || in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_hold beat %0d cyc %0d: got vld=%b y=%h last=%b flags=%b rdy=%b required 1 %h %b %b 0",
                             k, s, out_valid, y_out, out_last, flags, in_ready,
                             exp.r[k*BUS_W +: BUS_W], (k == BEATS-1), exp.f);
                end
                if (s < 3) @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    // Table of operand pairs sent back to back, drained with out_ready high.
    task automatic test_main();
        vec_t tbl[$];
        exp_t exp;
        int   cyc;
        tbl.push_back('{16'h3E00, 16'h4200, 16'h4400, 3'b000});
`ifdef LOGMUL_CORR_EN
        tbl.push_back('{16'h3D00, 16'h3D00, 16'h3E40, 3'b000});
`else
        tbl.push_back('{16'h3D00, 16'h3D00, 16'h3E00, 3'b000});
`endif
        tbl.push_back('{16'h4000, 16'hC000, 16'hC400, 3'b000});
        tbl.push_back('{16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010});
        tbl.push_back('{16'h0400, 16'h0400, 16'h0000, 3'b001});
        tbl.push_back('{16'h7C00, 16'h0000, 16'h7E00, 3'b100});
        tbl.push_back('{16'h7E01, 16'h3C00, 16'h7E00, 3'b100});
        tbl.push_back('{16'h7C00, 16'h4000, 16'h7C00, 3'b000});
        tbl.push_back('{16'h8000, 16'h4000, 16'h8000, 3'b000});
        tbl.push_back('{16'h0001, 16'h4000, 16'h0000, 3'b000});
        foreach (tbl[i]) begin
            send_operand(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f);
            exp = sb.pop_front();
            for (int k = 0; k < BEATS; k++) begin
                cyc = 0;
                while (out_valid !== 1'b1 && cyc < TIMEOUT) begin
                    @(negedge clk);
                    cyc++;
                end
                vectors++;
                if (out_valid !== 1'b1 || (k == 0 && cyc != 1)) begin
                    errors++;
                    $display("[TB] FAIL latency vec %0d beat %0d: got vld=%b after %0d cycles required 1 after 1",
                             i, k, out_valid, cyc);
                end
                vectors++;
                if (y_out !== exp.r[k*BUS_W +: BUS_W] || out_last !== (k == BEATS-1) || flags !== exp.f) begin
                    errors++;
                    $display("[TB] FAIL result vec %0d (%h*%h) beat %0d: got y=%h last=%b flags=%b required y=%h last=%b flags=%b",
                             i, tbl[i].a, tbl[i].b, k, y_out, out_last, flags,
                             exp.r[k*BUS_W +: BUS_W], (k == BEATS-1), exp.f);
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL return_to_load vec %0d: got vld=%b rdy=%b required 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    // A stale half-operand is discarded by reset before a fresh 2.0*2.0.
    task automatic test_reset_midop();
        exp_t exp;
        int   cyc;
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 8'hAA;
        b_in     = 8'h55;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_reset_outputs: got rdy=%b vld=%b required 0 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        send_operand(16'h4000, 16'h4000, 16'h4400, 3'b000);
        exp = sb.pop_front();
        for (int k = 0; k < BEATS; k++) begin
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < TIMEOUT) begin
                @(negedge clk);
                cyc++;
            end
            vectors++;
            if (out_valid !== 1'b1 || y_out !== exp.r[k*BUS_W +: BUS_W] ||
                out_last !== (k == BEATS-1) || flags !== exp.f) begin
                errors++;
                $display("[TB] FAIL midop_result beat %0d: got vld=%b y=%h last=%b flags=%b required 1 %h %b %b",
                         k, out_valid, y_out, out_last, flags,
                         exp.r[k*BUS_W +: BUS_W], (k == BEATS-1), exp.f);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_main();
        test_reset_midop();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/logmul_serial_afpm.md
# logmul_serial_afpm

Parametrised, handshaked successor to the byte-serial logarithmic (Mitchell) approximate floating-point multiplier. Operands of any IEEE-like format {sign, EXP_W, MAN_W} arrive over a BUS_W-wide beat interface, least-significant beat first. The block computes an approximate product with special-case handling and exception flags, then streams the result out over a backpressured beat interface. It sits between the pad-level byte mux and any downstream accumulator.

## Interface
- EXP_W, 5: exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10: stored mantissa width; must be ≥4.
- BUS_W, 8: beat width; W = 1+EXP_W+MAN_W must be a multiple of BUS_W; BEATS = W/BUS_W.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts an operand beat.
- a_in  in  BUS_W  operand A beat.
- b_in  in  BUS_W  operand B beat, same beat index as a_in.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts a result beat.
- y_out  out  BUS_W  result beat.
- out_last  out  1  high on the final result beat.
- flags  out  3  {nan, ovf, unf}; valid while out_valid, constant across all beats of one result.

## Operation
- FSM: LOAD → CALC → SEND → LOAD.
- LOAD: in_ready=1. Each in_valid&&in_ready stores beats into A[k*BUS_W +: BUS_W] and B[k*BUS_W +: BUS_W], k=0..BEATS-1. The last beat moves the FSM to CALC.
- CALC: one cycle. Result and flags are registered; the FSM moves to SEND.
- SEND: out_valid=1. y_out = R[k*BUS_W +: BUS_W]. k advances on out_valid&&out_ready. out_last=1 when k=BEATS-1. Acceptance of the last beat returns the FSM to LOAD.
- Datapath, with fa, fb the mantissa fields:
  - s = sa^sb.
  - S = fa+fb, width MAN_W+1.
  - E = ea+eb-bias, signed, width EXP_W+2.
  - If S[MAN_W]=1: E=E+1, mantissa = S[MAN_W-1:0].
  - Else: mantissa = S[MAN_W-1:0], plus correction if enabled.
- Special cases, in priority order:
  - Any NaN operand, or Inf×0 → canonical qNaN {0, all-ones exponent, 1, zeros}; nan=1. FP16: 0x7E00.
  - Either operand Inf → signed Inf.
  - Either operand has exponent 0 (zero or subnormal) → signed zero. Subnormal inputs are flushed; no flag is raised.
  - E ≥ 2^EXP_W-1 → signed Inf; ovf=1.
  - E ≤ 0 → signed zero; unf=1.

## Timing
- Reset (async, any state): FSM=LOAD, beat counter=0, operand and result registers=0.
- Output values while rst=1: in_ready=0, out_valid=0, y_out=0, out_last=0, flags=0.
- in_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation discards partial operands and any unsent result.
- Latency: out_valid rises after the second rising edge following acceptance of the final input beat.
- Minimum op period: 2*BEATS+1 cycles. Operations do not overlap; in_ready=0 in CALC and SEND.
- out_valid, y_out, out_last and flags hold stable while out_valid&&!out_ready.
- in_valid is ignored outside LOAD. out_ready is ignored outside SEND.

## Configuration
- LOGMUL_CORR_EN defined: adds a correction term in the non-carry branch only.
  - c = (fa[MAN_W-1:MAN_W-2] * fb[MAN_W-1:MAN_W-2]) << (MAN_W-4).
  - mantissa = S+c, saturated to all-ones if it reaches 2^MAN_W.
- LOGMUL_CORR_EN undefined: pure Mitchell. The carry branch is identical in both builds.

## Structure
- Package logmul_pkg holds:
  - FSM state enum.
  - Flag bit indices: NAN=2, OVF=1, UNF=0.
  - Constant functions for W, BEATS and bias.
  - Canonical-NaN constant function.
- Sub-module logmul_core: purely combinational datapath (A, B → R, flags), parametrised by EXP_W/MAN_W.
- Top level: beat counter, FSM, operand, result and flag registers.

## Test plan
All cases use the default parameters (FP16, 8-bit beats, 2 beats).
- A=0x3E00 (1.5), B=0x4200 (3.0), beats 0x00/0x00 then 0x3E/0x42 → y_out 0x00 then 0x44 (R=0x4400), out_last on beat 1, flags=0, in both builds.
- A=B=0x3D00 (1.25) → R=0x3E00 without LOGMUL_CORR_EN; R=0x3E40 with it.
- A=0x4000, B=0xC000 → R=0xC400. Repeat with out_ready held low for 3 cycles per beat; outputs must hold stable.
- A=B=0x7BFF → R=0x7C00, flags=3'b010.
- A=B=0x0400 → R=0x0000, flags=3'b001.
- A=0x7C00, B=0x0000 → R=0x7E00, flags=3'b100.
- Assert rst after one operand beat, then send A=0x4000, B=0x4000 → R=0x4400; the stale beat must be discarded.
